// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states, defaults.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned OP_W_DEF = 5;
    localparam int unsigned OP_LAST  = 10;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_MUL  = 5'd10
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } alu_state_e;

    // Codes 0..OP_LAST are defined; everything above is illegal.
    function automatic logic op_is_legal(input logic [31:0] op);
        return op <= 32'(OP_LAST);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// Ports:
//   clk_i, rst_n_i  clock / async active-low reset
//   start_i         load operands and begin (ignored while busy)
//   a_i, b_i        multiplicand / multiplier
//   busy_o          iteration in progress (registered)
//   done_c_o        last chunk retires at the coming edge (combinational)
//   prod_c_o        low XLEN bits of the product, valid with done_c_o
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_c_o,
    output logic [XLEN-1:0] prod_c_o
);

    localparam int unsigned STEPS = XLEN / MUL_BITS;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [XLEN-1:0]  a_q, b_q, acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [XLEN-1:0]  partial_c;
    logic [XLEN-1:0]  sum_c;

    // Partial product of the multiplicand with the current low chunk of the multiplier.
    assign partial_c = a_q * XLEN'(b_q[MUL_BITS-1:0]);
    assign sum_c     = acc_q + partial_c;

    // Operand shift registers, accumulator and chunk counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (busy_q) begin
            a_q   <= a_q << MUL_BITS;
            b_q   <= b_q >> MUL_BITS;
            acc_q <= sum_c;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= CNT_W'(STEPS - 1);
            busy_q <= 1'b1;
        end
    end

    assign busy_o   = busy_q;
    assign done_c_o = busy_q & (cnt_q == '0);
    assign prod_c_o = sum_c;

endmodule

// File: rtl/alu_pipe.sv
// Execute-stage ALU with valid/ready in and out channels and a registered result.
// Single-cycle ops return one cycle after accept; MUL uses alu_mul_iter.
// Ports:
//   clk_i, rst_n_i             clock / async active-low reset
//   in_valid_i, in_ready_o     input handshake (in_ready_o is combinational)
//   op_i, rs1_i, rs2_i         operation and operands
//   out_valid_o, out_ready_i   output handshake
//   rd_o, zero_o, illegal_o    result, result==0, undefined op code
//   busy_o                     multiplier iterating
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned MUL_BITS = 1,
    parameter int unsigned OP_W     = OP_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] rd_o,
    output logic            zero_o,
    output logic            illegal_o,
    output logic            busy_o
);

    localparam int unsigned SH_W = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            busy_q, busy_d;

    logic            accept_c;
    logic            is_mul_c;
    logic            legal_c;
    logic [SH_W-1:0] shamt_c;
    logic [XLEN-1:0] alu_res_c;
    logic            mul_start_c;
    logic            mul_busy;
    logic            mul_done_c;
    logic [XLEN-1:0] mul_prod_c;

    // A new op may enter only when idle and the output slot is free or draining.
    assign in_ready_o = (state_q == S_IDLE) & (~out_valid_q | out_ready_i);
    assign accept_c   = in_valid_i & in_ready_o;
    assign is_mul_c   = (op_i == OP_W'(OP_MUL));
    assign legal_c    = op_is_legal(32'(op_i));
    assign shamt_c    = rs2_i[SH_W-1:0];

    // Single-cycle result decode; MUL and illegal codes yield zero here.
    always_comb begin
        alu_res_c = '0;
        case (op_i)
            OP_W'(OP_ADD):  alu_res_c = rs1_i + rs2_i;
            OP_W'(OP_SUB):  alu_res_c = rs1_i - rs2_i;
            OP_W'(OP_AND):  alu_res_c = rs1_i & rs2_i;
            OP_W'(OP_OR):   alu_res_c = rs1_i | rs2_i;
            OP_W'(OP_XOR):  alu_res_c = rs1_i ^ rs2_i;
            OP_W'(OP_SLL):  alu_res_c = rs1_i << shamt_c;
            OP_W'(OP_SRL):  alu_res_c = rs1_i >> shamt_c;
            OP_W'(OP_SRA):  alu_res_c = $unsigned($signed(rs1_i) >>> shamt_c);
            OP_W'(OP_SLT):  alu_res_c = XLEN'($signed(rs1_i) < $signed(rs2_i));
            OP_W'(OP_SLTU): alu_res_c = XLEN'(rs1_i < rs2_i);
            default:        alu_res_c = '0;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~out_ready_i;
        rd_d        = rd_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        mul_start_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c) begin
                        mul_start_c = 1'b1;
                        state_d     = S_MUL;
                    end else begin
                        rd_d        = alu_res_c;
                        zero_d      = (alu_res_c == '0);
                        illegal_d   = ~legal_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_done_c) begin
                    rd_d        = mul_prod_c;
                    zero_d      = (mul_prod_c == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_MUL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
        end
    end

    alu_mul_iter #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (mul_start_c),
        .a_i      (rs1_i),
        .b_i      (rs2_i),
        .busy_o   (mul_busy),
        .done_c_o (mul_done_c),
        .prod_c_o (mul_prod_c)
    );

    assign out_valid_o = out_valid_q;
    assign rd_o        = rd_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results, monitor pops on output handshake.
module tb_alu_pipe;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i, in_ready_o;
    logic [4:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] rd_o;
    logic        zero_o, illegal_o, busy_o;

    // Second instance with MUL_BITS=4 for the multiplier latency check.
    logic        v4_in, r4_in, v4_out, z4, il4, b4;
    logic [4:0]  op4;
    logic [31:0] a4, bb4, rd4;

    int total = 0;
    int bad   = 0;
    int last_wait;
    logic [33:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    alu_pipe #(.XLEN(32), .MUL_BITS(1), .OP_W(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .rd_o(rd_o), .zero_o(zero_o), .illegal_o(illegal_o), .busy_o(busy_o)
    );

    alu_pipe #(.XLEN(32), .MUL_BITS(4), .OP_W(5)) dut4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .in_valid_i(v4_in), .in_ready_o(r4_in),
        .op_i(op4), .rs1_i(a4), .rs2_i(bb4),
        .out_valid_o(v4_out), .out_ready_i(1'b1),
        .rd_o(rd4), .zero_o(z4), .illegal_o(il4), .busy_o(b4)
    );

    // Reference model: {illegal, zero, rd} from the op definitions.
    function automatic logic [33:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        int          sh;
        logic [63:0] p;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        p   = 64'(a) * 64'(b);
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << sh;
            5'd6:  r = a >> sh;
            5'd7:  r = $unsigned($signed(a) >>> sh);
            5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd10: r = p[31:0];
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        return {ill, (r == 32'd0), r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one op and hold it until accepted; push the model result on acceptance.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit rnd);
        bit ok;
        int w;
        ok = 1'b0;
        w  = 0;
        in_valid_i = 1'b1;
        op_i  = op;
        rs1_i = a;
        rs2_i = b;
        forever begin
            if (rnd) out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            ok = in_ready_o;
            @(posedge clk_i);
            #1;
            if (ok) break;
            w++;
            if (w > 500) begin
                chk("accept_timeout", 32'(w), 32'd0);
                break;
            end
        end
        if (ok) exp_q.push_back(model(op, a, b));
        in_valid_i = 1'b0;
        last_wait  = w;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    // Monitor: compare every output transfer against the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_n_i && out_valid_o && out_ready_i) begin
            logic [33:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected actual=%h required=none", {illegal_o, zero_o, rd_o});
            end else begin
                e = exp_q.pop_front();
                if ({illegal_o, zero_o, rd_o} !== e) begin
                    bad++;
                    $display("FAIL sb_result actual=%h required=%h", {illegal_o, zero_o, rd_o}, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] held;
        logic [4:0]  rop;

        rst_n_i = 1'b0;
        in_valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; out_ready_i = 1'b1;
        v4_in = 1'b0; op4 = '0; a4 = '0; bb4 = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_out_valid", 32'(out_valid_o), 32'd0);
        chk("reset_rd", rd_o, 32'd0);
        chk("reset_flags", {29'd0, zero_o, illegal_o, busy_o}, 32'd0);
        rst_n_i = 1'b1;
        #1;
        chk("ready_after_reset", 32'(in_ready_o), 32'd1);

        // 1: wrap-around add
        issue(5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("add_wrap_valid", 32'(out_valid_o), 32'd1);
        chk("add_wrap_rd", rd_o, 32'd0);
        chk("add_wrap_zero", 32'(zero_o), 32'd1);

        // 2: shifts and compares
        issue(5'd7, 32'h8000_0000, 32'h21, 1'b0);
        chk("sra_rd", rd_o, 32'hC000_0000);
        issue(5'd8, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("slt_rd", rd_o, 32'd1);
        issue(5'd9, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("sltu_rd", rd_o, 32'd0);

        // 3: iterative multiply, 1 bit per cycle
        issue(5'd10, 32'h0001_0003, 32'h0002_0005, 1'b0);
        chk("mul_busy", 32'(busy_o), 32'd1);
        chk("mul_in_ready", 32'(in_ready_o), 32'd0);
        wait_valid(n);
        chk("mul1_latency", 32'(n), 32'd32);
        chk("mul1_rd", rd_o, 32'h000B_000F);
        chk("mul1_busy_done", 32'(busy_o), 32'd0);

        // 3b: 4 bits per cycle on the second instance
        v4_in = 1'b1; op4 = 5'd10; a4 = 32'h0001_0003; bb4 = 32'h0002_0005;
        @(posedge clk_i);
        #1;
        v4_in = 1'b0;
        n = 0;
        while (!v4_out && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("mul4_latency", 32'(n), 32'd8);
        chk("mul4_rd", rd4, 32'h000B_000F);

        // 4: back-to-back adds, then output stall
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 8; i++) begin
            issue(5'd0, 32'(i * 17), 32'(i + 100), 1'b0);
            chk("b2b_wait", 32'(last_wait), 32'd0);
            chk("b2b_valid", 32'(out_valid_o), 32'd1);
        end
        out_ready_i = 1'b0;
        held = rd_o;
        in_valid_i = 1'b1; op_i = 5'd1; rs1_i = 32'd50; rs2_i = 32'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready_o), 32'd0);
            @(posedge clk_i);
            #1;
            chk("stall_rd_hold", rd_o, held);
            chk("stall_valid_hold", 32'(out_valid_o), 32'd1);
        end
        out_ready_i = 1'b1;
        issue(5'd1, 32'd50, 32'd8, 1'b0);
        chk("stall_op_kept", rd_o, 32'd42);

        // 5: illegal op, then legal op clears the flag
        issue(5'd31, 32'h1234, 32'h5678, 1'b0);
        chk("illegal_flag", 32'(illegal_o), 32'd1);
        chk("illegal_rd", rd_o, 32'd0);
        chk("illegal_zero", 32'(zero_o), 32'd1);
        issue(5'd2, 32'hF0F0, 32'h0FF0, 1'b0);
        chk("illegal_cleared", 32'(illegal_o), 32'd0);
        chk("and_rd", rd_o, 32'h00F0);

        // 6: reset in the middle of a multiply
        @(posedge clk_i);
        #1;
        issue(5'd10, 32'h0000_0007, 32'h0000_0009, 1'b0);
        repeat (9) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_valid", 32'(out_valid_o), 32'd0);
        chk("rst_mid_rd", rd_o, 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_valid", 32'(out_valid_o), 32'd0);
        chk("post_rst_ready", 32'(in_ready_o), 32'd1);
        issue(5'd0, 32'd2, 32'd3, 1'b0);
        chk("post_rst_add", rd_o, 32'd5);

        // Random traffic with random output back-pressure
        for (int i = 0; i < 300; i++) begin
            rop = 5'($urandom_range(0, 12));
            if (rop > 5'd10) rop = 5'($urandom_range(11, 31));
            case ($urandom_range(0, 3))
                0:       issue(rop, 32'h8000_0000 >> $urandom_range(0, 31), $urandom, 1'b1);
                1:       issue(rop, $urandom, 32'($urandom_range(0, 40)), 1'b1);
                default: issue(rop, $urandom, $urandom, 1'b1);
            endcase
        end

        out_ready_i = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid_o) && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
